// File: rtl/audio_seq_pkg.sv
// Shared encodings for the audio command sequencer: command word layout, kinds, FSM states.
// Pure definitions; no latency or flow control of its own.
package audio_seq_pkg;

  localparam int CMD_W    = 40;
  localparam int KIND_HI  = 39;
  localparam int KIND_LO  = 38;
  localparam int OP_HI    = 37;
  localparam int OP_LO    = 35;
  localparam int CH_HI    = 34;
  localparam int CH_LO    = 33;
  localparam int RSVD_BIT = 32;
  localparam int DATA_HI  = 31;
  localparam int DATA_LO  = 0;

  typedef enum logic [1:0] {
    K_WRITE = 2'b00,
    K_WAIT  = 2'b01,
    K_JUMP  = 2'b10,
    K_END   = 2'b11
  } kind_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_FETCH = 2'b01,
    S_EXEC  = 2'b10,
    S_WAIT  = 2'b11
  } state_e;

endpackage

// File: rtl/audio_command_sequencer_if.sv
// Host load path plus synthesizer-master write port of the sequencer.
// master = sequencer side, slave = host/synth side; no backpressure, strobe is a fire-and-forget pulse.
interface audio_command_sequencer_if
  import audio_seq_pkg::*;
#(
  parameter int ADDR_W = 6
);
  logic              start;
  logic              stop;
  logic              load_we;
  logic [ADDR_W-1:0] load_addr;
  logic [CMD_W-1:0]  load_data;
  logic [2:0]        cmd_opcode;
  logic [1:0]        cmd_channel;
  logic [31:0]       cmd_data;
  logic              cmd_strobe;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] pc;

  modport master (
    input  start, stop, load_we, load_addr, load_data,
    output cmd_opcode, cmd_channel, cmd_data, cmd_strobe, busy, done, pc
  );

  modport slave (
    output start, stop, load_we, load_addr, load_data,
    input  cmd_opcode, cmd_channel, cmd_data, cmd_strobe, busy, done, pc
  );
endinterface

// File: rtl/audio_seq_cmd_ram.sv
// Simple dual-port command store, one write port and a registered read port (1-cycle latency).
// No reset on storage or read register so it maps onto a block RAM; no flow control.
module audio_seq_cmd_ram
  import audio_seq_pkg::*;
#(
  parameter int ADDR_W = 6
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [CMD_W-1:0]  i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [CMD_W-1:0]  o_rdata
);

  logic [CMD_W-1:0] r_mem [2**ADDR_W];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    o_rdata <= r_mem[i_raddr];
  end

endmodule

// File: rtl/audio_command_sequencer.sv
// Steps through preloaded WRITE/WAIT/JUMP/END words, driving the synth master write port.
// One EXEC every 2 cycles (WAIT adds N*TICK_DIV); stop aborts next cycle, strobe is never backpressured.
module audio_command_sequencer
  import audio_seq_pkg::*;
#(
  parameter int ADDR_W   = 6,
  parameter int TICK_DIV = 50000
) (
  input  logic CLOCK_50,
  input  logic reset,
  audio_command_sequencer_if.master bus
);

  localparam int PRE_W = $clog2(TICK_DIV);
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);

  state_e            r_state, w_next;
  logic [ADDR_W-1:0] r_pc;
  logic [CMD_W-1:0]  w_rd;
  logic [31:0]       r_ticks;
  logic [PRE_W-1:0]  r_pre;
  logic              r_arm, r_strobe, r_done;
  logic [2:0]        r_opcode;
  logic [1:0]        r_channel;
  logic [31:0]       r_data;

  kind_e             w_kind;
  logic [31:0]       w_arg;
  logic              w_tick, w_last_tick, w_ram_we, w_unused_rsvd;
  logic              w_pc_clr, w_pc_inc, w_pc_jump, w_cmd_load, w_wait_load, w_done_set;

  assign w_kind        = kind_e'(w_rd[KIND_HI:KIND_LO]);
  assign w_arg         = w_rd[DATA_HI:DATA_LO];
  assign w_unused_rsvd = w_rd[RSVD_BIT];
  assign w_tick        = (r_pre == PRE_MAX);
  assign w_last_tick   = w_tick && (r_ticks == 32'd1);
  // Loads are only accepted in IDLE, so a running program can never be rewritten underneath itself.
  assign w_ram_we      = bus.load_we && (r_state == S_IDLE);

  audio_seq_cmd_ram #(.ADDR_W(ADDR_W)) u_ram (
    .i_clk   (CLOCK_50),
    .i_we    (w_ram_we),
    .i_waddr (bus.load_addr),
    .i_wdata (bus.load_data),
    .i_raddr (r_pc),
    .o_rdata (w_rd)
  );

  always_ff @(posedge CLOCK_50) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (bus.stop) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (bus.start) w_next = S_FETCH;
        S_FETCH: w_next = S_EXEC;
        S_EXEC: begin
          case (w_kind)
            K_WRITE: w_next = S_FETCH;
            K_WAIT:  w_next = (w_arg == 32'd0) ? S_FETCH : S_WAIT;
            K_JUMP:  w_next = S_FETCH;
            K_END:   w_next = S_IDLE;
            default: w_next = S_IDLE;
          endcase
        end
        S_WAIT:  if (w_last_tick) w_next = S_FETCH;
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_pc_clr    = 1'b0;
    w_pc_inc    = 1'b0;
    w_pc_jump   = 1'b0;
    w_cmd_load  = 1'b0;
    w_wait_load = 1'b0;
    w_done_set  = 1'b0;
    if (!bus.stop) begin
      case (r_state)
        S_IDLE: w_pc_clr = bus.start;
        S_EXEC: begin
          case (w_kind)
            K_WRITE: begin
              w_cmd_load = 1'b1;
              w_pc_inc   = 1'b1;
            end
            K_WAIT: begin
              w_pc_inc    = (w_arg == 32'd0);
              w_wait_load = (w_arg != 32'd0);
            end
            K_JUMP:  w_pc_jump  = 1'b1;
            K_END:   w_done_set = 1'b1;
            default: ;
          endcase
        end
        S_WAIT:  w_pc_inc = w_last_tick;
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_pc      <= '0;
      r_opcode  <= '0;
      r_channel <= '0;
      r_data    <= '0;
      r_arm     <= 1'b0;
      r_strobe  <= 1'b0;
      r_done    <= 1'b0;
      r_ticks   <= '0;
      r_pre     <= '0;
    end else begin
      if (w_pc_clr)       r_pc <= '0;
      else if (w_pc_inc)  r_pc <= r_pc + 1'b1;
      else if (w_pc_jump) r_pc <= w_rd[ADDR_W-1:0];

      if (w_cmd_load) begin
        r_opcode  <= w_rd[OP_HI:OP_LO];
        r_channel <= w_rd[CH_HI:CH_LO];
        r_data    <= w_arg;
      end
      // Strobe trails the data by one cycle so the master sees stable data on its strobe edge.
      r_arm    <= w_cmd_load;
      r_strobe <= r_arm && !bus.stop;
      r_done   <= w_done_set;

      if (w_wait_load) begin
        r_ticks <= w_arg;
        r_pre   <= '0;
      end else if (r_state == S_WAIT) begin
        r_pre <= w_tick ? '0 : r_pre + 1'b1;
        if (w_tick) r_ticks <= r_ticks - 32'd1;
      end
    end
  end

  assign bus.cmd_opcode  = r_opcode;
  assign bus.cmd_channel = r_channel;
  assign bus.cmd_data    = r_data;
  assign bus.cmd_strobe  = r_strobe;
  assign bus.done        = r_done;
  assign bus.busy        = (r_state != S_IDLE);
  assign bus.pc          = r_pc;

endmodule

// File: tb/tb_audio_command_sequencer.sv
// Directed bench for audio_command_sequencer with TICK_DIV=4: per-cycle vector table plus timing sequences.
module tb_audio_command_sequencer;

  logic clk;
  logic reset;
  int   n_pass;
  int   n_total;
  int   cnt;

  audio_command_sequencer_if #(.ADDR_W(6)) bus ();

  audio_command_sequencer #(.ADDR_W(6), .TICK_DIV(4)) dut (
    .CLOCK_50 (clk),
    .reset    (reset),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        start;
    logic        stop;
    logic        we;
    logic [5:0]  addr;
    logic [39:0] wdat;
    logic [45:0] expv;
  } vec_t;

  vec_t tbl [11];

  function automatic logic [39:0] cw_write(logic [2:0] op, logic [1:0] ch, logic [31:0] d);
    return {2'b00, op, ch, 1'b0, d};
  endfunction
  function automatic logic [39:0] cw_wait(logic [31:0] n);
    return {2'b01, 6'b0, n};
  endfunction
  function automatic logic [39:0] cw_jump(logic [5:0] t);
    return {2'b10, 32'b0, t};
  endfunction
  function automatic logic [39:0] cw_end();
    return {2'b11, 38'b0};
  endfunction

  // {busy, done, strobe, pc, opcode, channel, data}
  function automatic logic [45:0] ex(logic b, logic d, logic s, logic [5:0] p,
                                     logic [2:0] op, logic [1:0] ch, logic [31:0] dat);
    return {b, d, s, p, op, ch, dat};
  endfunction
  function automatic logic [45:0] out_vec();
    return {bus.busy, bus.done, bus.cmd_strobe, bus.pc, bus.cmd_opcode, bus.cmd_channel, bus.cmd_data};
  endfunction
  function automatic vec_t mk(logic st, logic sp, logic we, logic [5:0] a, logic [39:0] d, logic [45:0] e);
    vec_t v;
    v.start = st; v.stop = sp; v.we = we; v.addr = a; v.wdat = d; v.expv = e;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(negedge clk);
    cnt++;
  endtask

  task automatic load(input logic [5:0] a, input logic [39:0] d);
    bus.load_we = 1'b1; bus.load_addr = a; bus.load_data = d;
    step();
    bus.load_we = 1'b0;
  endtask

  // Cycle 0 is the cycle in which start is sampled; cnt tracks the cycle number afterwards.
  task automatic go();
    bus.start = 1'b1;
    cnt = 0;
    step();
    bus.start = 1'b0;
  endtask

  task automatic wait_for_strobe(input int limit);
    while (!bus.cmd_strobe && cnt < limit) step();
  endtask

  task automatic wait_for_done(input int limit);
    while (!bus.done && cnt < limit) step();
  endtask

  task automatic halt();
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [39:0] w0, wold, wa;
    int          n;
    n_pass = 0; n_total = 0; cnt = 0;
    bus.start = 1'b0; bus.stop = 1'b0; bus.load_we = 1'b0;
    bus.load_addr = '0; bus.load_data = '0;
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;

    // Reserved bit set in w0 to show it is ignored; addr 0 is rewritten in the start cycle.
    w0   = {2'b00, 3'd3, 2'd1, 1'b1, 32'h000A8000};
    wold = cw_write(3'd1, 2'd2, 32'h00001234);
    tbl[0]  = mk(0, 0, 1, 6'd1, cw_end(), ex(0, 0, 0, 6'd0, 3'd0, 2'd0, 32'h0));
    tbl[1]  = mk(0, 0, 1, 6'd0, wold,     ex(0, 0, 0, 6'd0, 3'd0, 2'd0, 32'h0));
    tbl[2]  = mk(1, 0, 1, 6'd0, w0,       ex(0, 0, 0, 6'd0, 3'd0, 2'd0, 32'h0));
    tbl[3]  = mk(0, 0, 0, 6'd0, '0,       ex(1, 0, 0, 6'd0, 3'd0, 2'd0, 32'h0));
    tbl[4]  = mk(0, 0, 0, 6'd0, '0,       ex(1, 0, 0, 6'd0, 3'd0, 2'd0, 32'h0));
    tbl[5]  = mk(0, 0, 0, 6'd0, '0,       ex(1, 0, 0, 6'd1, 3'd3, 2'd1, 32'h000A8000));
    tbl[6]  = mk(0, 0, 0, 6'd0, '0,       ex(1, 0, 1, 6'd1, 3'd3, 2'd1, 32'h000A8000));
    tbl[7]  = mk(0, 0, 0, 6'd0, '0,       ex(0, 1, 0, 6'd1, 3'd3, 2'd1, 32'h000A8000));
    tbl[8]  = mk(1, 1, 0, 6'd0, '0,       ex(0, 0, 0, 6'd1, 3'd3, 2'd1, 32'h000A8000));
    tbl[9]  = mk(0, 0, 0, 6'd0, '0,       ex(0, 0, 0, 6'd1, 3'd3, 2'd1, 32'h000A8000));
    tbl[10] = mk(0, 0, 0, 6'd0, '0,       ex(0, 0, 0, 6'd1, 3'd3, 2'd1, 32'h000A8000));

    for (int i = 0; i < 11; i++) begin
      chk($sformatf("vec%0d", i), 64'(out_vec()), 64'(tbl[i].expv));
      bus.start = tbl[i].start; bus.stop = tbl[i].stop; bus.load_we = tbl[i].we;
      bus.load_addr = tbl[i].addr; bus.load_data = tbl[i].wdat;
      step();
    end
    bus.start = 1'b0; bus.stop = 1'b0; bus.load_we = 1'b0;

    // WAIT 3: WAIT EXEC at cycle 2, strobe 3*4+2+2 later.
    load(6'd0, cw_wait(32'd3));
    load(6'd1, cw_write(3'd5, 2'd2, 32'hDEADBEEF));
    load(6'd2, cw_end());
    go();
    wait_for_strobe(60);
    chk("wait3_strobe_cycle", 64'(cnt), 64'd18);
    chk("wait3_data", 64'(bus.cmd_data), 64'hDEADBEEF);
    wait_for_done(60);
    chk("wait3_done_cycle", 64'(cnt), 64'd19);
    chk("wait3_busy_at_done", 64'(bus.busy), 64'd0);

    load(6'd0, cw_wait(32'd0));
    go();
    wait_for_strobe(60);
    chk("wait0_strobe_cycle", 64'(cnt), 64'd6);
    wait_for_done(60);
    chk("wait0_done_cycle", 64'(cnt), 64'd7);

    // WRITE/JUMP loop; start and load_we while busy must have no effect.
    wa = cw_write(3'd7, 2'd3, 32'hCAFE0001);
    load(6'd0, wa);
    load(6'd1, cw_jump(6'd0));
    go();
    wait_for_strobe(20);
    chk("loop_first_strobe", 64'(cnt), 64'd4);
    step();
    bus.start = 1'b1; bus.load_we = 1'b1; bus.load_addr = 6'd0;
    bus.load_data = cw_write(3'd1, 2'd1, 32'h00005555);
    step();
    bus.start = 1'b0; bus.load_we = 1'b0;
    wait_for_strobe(20);
    chk("loop_second_strobe", 64'(cnt), 64'd8);
    chk("loop_busy_kept", 64'(bus.busy), 64'd1);
    repeat (3) step();
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
    chk("stop_busy", 64'(bus.busy), 64'd0);
    chk("stop_armed_strobe", 64'(bus.cmd_strobe), 64'd0);
    chk("stop_data_held", 64'(bus.cmd_data), 64'hCAFE0001);
    n = 0;
    repeat (10) begin
      step();
      if (bus.cmd_strobe) n++;
    end
    chk("stop_no_more_strobes", 64'(n), 64'd0);

    go();
    wait_for_strobe(20);
    chk("readback_cycle", 64'(cnt), 64'd4);
    chk("readback_data", 64'(bus.cmd_data), 64'hCAFE0001);
    halt();

    // pc wrap 63 -> 0 via JUMP 63 at word 0.
    for (int a = 2; a < 64; a++) load(6'(a), cw_write(3'd1, 2'd0, 32'(a)));
    load(6'd1, cw_end());
    load(6'd0, cw_jump(6'd63));
    go();
    step();
    step();
    chk("wrap_pc63", 64'(bus.pc), 64'd63);
    step();
    step();
    chk("wrap_pc0", 64'(bus.pc), 64'd0);
    chk("wrap_data", 64'(bus.cmd_data), 64'd63);
    step();
    chk("wrap_strobe", 64'(bus.cmd_strobe), 64'd1);
    halt();

    // Reset in WAIT, then replay without reload.
    load(6'd0, cw_write(3'd2, 2'd3, 32'h00000077));
    load(6'd1, cw_wait(32'd5));
    load(6'd2, cw_write(3'd6, 2'd0, 32'h00000099));
    load(6'd3, cw_end());
    go();
    wait_for_strobe(20);
    chk("pre_reset_strobe", 64'(cnt), 64'd4);
    step();
    step();
    chk("in_wait_busy", 64'(bus.busy), 64'd1);
    reset = 1'b1;
    step();
    chk("reset_outputs", 64'(out_vec()), 64'd0);
    reset = 1'b0;
    step();
    go();
    wait_for_strobe(20);
    chk("replay_strobe1", 64'(cnt), 64'd4);
    chk("replay_data1", 64'(bus.cmd_data), 64'h77);
    step();
    wait_for_strobe(60);
    chk("replay_strobe2", 64'(cnt), 64'd28);
    chk("replay_data2", 64'({bus.cmd_opcode, bus.cmd_data}), 64'h6_00000099);
    wait_for_done(60);
    chk("replay_done", 64'(cnt), 64'd29);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
